lc3_mem_arbiter: RTL and testbench
==================================

# lc3_mem_arbiter

Two-port arbiter and sequencer in front of the single-ported LC3_MEMORY. It shares the memory between the instruction-fetch port (read-only) and the data port (read/write, driven by MAR/MDR logic). It grants one requester at a time, drives the memory's ADDR/DATAin/R_W/MEM_EN, captures MEMout, and returns it with a one-cycle acknowledge.

## Interface
- FAIR, 1, 1 = round-robin between ports on simultaneous requests; 0 = data port always wins.
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  16  fetch address; stable while if_req.
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  16  fetched word; holds its value until the next fetch completes.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req.
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_ack  out  1  one-cycle pulse; d_rdata valid on reads.
- d_rdata  out  16  read word; unchanged by writes.
- mem_addr  out  16  to LC3_MEMORY ADDR.
- mem_datain  out  16  to LC3_MEMORY DATAin.
- mem_r_w  out  1  to LC3_MEMORY R_W (1 = write).
- mem_en  out  1  to LC3_MEMORY MEM_EN.
- mem_out  in  16  from LC3_MEMORY MEMout.
- busy  out  1  high in every state except IDLE.
- grant  out  1  owner of the current access: 0 = fetch, 1 = data; holds its value in IDLE.

## Operation
- The FSM has four states: IDLE, ACCESS, CAPTURE, DONE. All outputs are registered.
- **IDLE**
  - No request: stay in IDLE.
  - On a request: choose the winner, latch its address, data and we into mem_*, drive mem_en = 1, and go to ACCESS.
  - The fetch port always drives mem_r_w = 0 and mem_datain = 0.
- **ACCESS**
  - Memory samples on this edge; a write commits here.
  - Drive mem_en = 0 and mem_r_w = 0, then go to CAPTURE.
  - mem_addr holds its value.
- **CAPTURE**
  - On a read, register mem_out into the winner's rdata.
  - Assert the winner's ack and go to DONE.
- **DONE**
  - Ack is high for exactly this cycle.
  - Go to IDLE unconditionally; req is ignored in DONE, so a requester that drops req on seeing ack is not re-granted.
- **Arbitration**
  - A single request is granted regardless of FAIR.
  - Simultaneous requests with FAIR = 1: grant the port not granted last.
  - Simultaneous requests with FAIR = 0: grant the data port.
  - last_grant updates on every grant.
- A request that arrives while busy waits; it is evaluated on the first IDLE cycle.
- Address and data are latched at grant. Input changes after grant do not affect the access in flight.

## Timing
- Reset values (asynchronous, immediate):
  - FSM in IDLE.
  - mem_addr, mem_datain, if_rdata, d_rdata = 16'h0000.
  - mem_r_w, mem_en, if_ack, d_ack, busy = 0.
  - grant = 0.
  - last_grant = 1 (data), so the first tie goes to fetch.
- Latency:
  - Request seen at edge E0.
  - mem_en high from E0 to E1.
  - rdata is captured and ack rises at E2.
  - ack falls at E3, with the FSM back in IDLE.
  - The next grant is possible at E4.
  - Throughput is at most one access per 4 cycles.
- Reset mid-access: mem_en and ack drop at once. A write in ACCESS is not guaranteed to commit and no ack is issued; the requester must reissue.
- A req that drops before its grant is lost silently. A req that drops after its grant does not abort the access; ack is still issued.

## Test plan
- **Fetch read:** preload 16'h00A5 at 16'h0001, then pulse if_req with if_addr = 16'h0001. Expect mem_en high for exactly 1 cycle, if_ack 2 cycles after the grant edge with if_rdata = 16'h00A5, and busy low the following cycle.
- **Data write then read:** d_we = 1, d_addr = 16'h0002, d_wdata = 16'h00FE, with mem_r_w = 1 during ACCESS. Then a read of 16'h0002 returns d_rdata = 16'h00FE. d_rdata is not updated by the write.
- **Tie, FAIR = 1:** both requests held high continuously. Grants must alternate fetch, data, fetch, data; the first grant goes to fetch after reset; one ack every 4 cycles.
- **Tie, FAIR = 0:** same stimulus. The data port wins every tie and fetch is granted only when d_req is low.
- **Late request:** assert d_req during the fetch's ACCESS state. The fetch completes unchanged, then data is granted on the first IDLE edge, with no extra ack pulses.
- **Reset mid-write:** drop rst_n during ACCESS. All outputs go to their reset values immediately, no d_ack is issued, and after release a fresh request completes normally.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - two-port arbiter/sequencer in front of LC3_MEMORY
//
// Shares the single-ported memory between the instruction-fetch port
// (read-only) and the data port (read/write). One access at a time runs
// through IDLE -> ACCESS -> CAPTURE -> DONE, so each access takes 4 cycles.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   if_req/if_addr               fetch request and address
//   if_ack/if_rdata              one-cycle ack, fetched word (held)
//   d_req/d_we/d_addr/d_wdata    data request, write enable, address, data
//   d_ack/d_rdata                one-cycle ack, read word (writes leave it alone)
//   mem_addr/mem_datain/mem_r_w/mem_en   drive LC3_MEMORY (r_w 1 = write)
//   mem_out                      LC3_MEMORY MEMout
//   busy                         high whenever not IDLE
//   grant                        owner of current access (0 fetch, 1 data)
// Parameter FAIR: 1 = round-robin on ties, 0 = data port wins ties.

module lc3_mem_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_datain,
  output logic        mem_r_w,
  output logic        mem_en,
  input  logic [15:0] mem_out,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t      state, state_n;
  logic        last_grant, last_grant_n;
  // Write flag of the access in flight; mem_r_w is cleared in ACCESS, so
  // CAPTURE needs its own copy to know whether to update rdata.
  logic        acc_we, acc_we_n;
  logic [15:0] mem_addr_n, mem_datain_n, if_rdata_n, d_rdata_n;
  logic        mem_r_w_n, mem_en_n, if_ack_n, d_ack_n, busy_n, grant_n;
  logic        pick_data;

  // Data wins when fetch is idle, or on a tie when unfair or when fetch
  // was the previous owner.
  always_comb begin
    pick_data = d_req && (!if_req || !FAIR || !last_grant);
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    acc_we_n     = acc_we;
    mem_addr_n   = mem_addr;
    mem_datain_n = mem_datain;
    mem_r_w_n    = mem_r_w;
    mem_en_n     = mem_en;
    if_rdata_n   = if_rdata;
    d_rdata_n    = d_rdata;
    if_ack_n     = 1'b0;
    d_ack_n      = 1'b0;
    busy_n       = busy;
    grant_n      = grant;

    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant_n      = pick_data;
          last_grant_n = pick_data;
          if (pick_data) begin
            mem_addr_n   = d_addr;
            mem_datain_n = d_wdata;
            mem_r_w_n    = d_we;
            acc_we_n     = d_we;
          end else begin
            mem_addr_n   = if_addr;
            mem_datain_n = 16'h0000;
            mem_r_w_n    = 1'b0;
            acc_we_n     = 1'b0;
          end
          mem_en_n = 1'b1;
          busy_n   = 1'b1;
          state_n  = ACCESS;
        end
      end
      ACCESS: begin
        // Memory samples the request on the edge leaving this state.
        mem_en_n  = 1'b0;
        mem_r_w_n = 1'b0;
        state_n   = CAPTURE;
      end
      CAPTURE: begin
        if (grant) begin
          if (!acc_we) d_rdata_n = mem_out;
          d_ack_n = 1'b1;
        end else begin
          if_rdata_n = mem_out;
          if_ack_n   = 1'b1;
        end
        state_n = DONE;
      end
      DONE: begin
        // Requests are ignored here so a port dropping req on ack is not
        // granted a second time.
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        mem_en_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      acc_we     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_datain <= 16'h0000;
      mem_r_w    <= 1'b0;
      mem_en     <= 1'b0;
      if_rdata   <= 16'h0000;
      d_rdata    <= 16'h0000;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      busy       <= 1'b0;
      grant      <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      acc_we     <= acc_we_n;
      mem_addr   <= mem_addr_n;
      mem_datain <= mem_datain_n;
      mem_r_w    <= mem_r_w_n;
      mem_en     <= mem_en_n;
      if_rdata   <= if_rdata_n;
      d_rdata    <= d_rdata_n;
      if_ack     <= if_ack_n;
      d_ack      <= d_ack_n;
      busy       <= busy_n;
      grant      <= grant_n;
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - directed bench for lc3_mem_arbiter (FAIR=1 and FAIR=0)

module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0000;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_wdata = 16'h0000;

  // FAIR=1 instance outputs
  logic        if_ack, d_ack, mem_r_w, mem_en, busy, grant;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_datain, mem_out;
  // FAIR=0 instance outputs
  logic        nf_if_ack, nf_d_ack, nf_mem_r_w, nf_mem_en, nf_busy, nf_grant;
  logic [15:0] nf_if_rdata, nf_d_rdata, nf_mem_addr, nf_mem_datain, nf_mem_out;

  logic [15:0] mem_f  [16];
  logic [15:0] mem_nf [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lc3_mem_arbiter #(.FAIR(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_r_w(mem_r_w),
    .mem_en(mem_en), .mem_out(mem_out), .busy(busy), .grant(grant)
  );

  lc3_mem_arbiter #(.FAIR(1'b0)) u_dut_nf (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(nf_if_ack), .if_rdata(nf_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(nf_d_ack), .d_rdata(nf_d_rdata),
    .mem_addr(nf_mem_addr), .mem_datain(nf_mem_datain), .mem_r_w(nf_mem_r_w),
    .mem_en(nf_mem_en), .mem_out(nf_mem_out), .busy(nf_busy), .grant(nf_grant)
  );

  // Synchronous single-port memory models (16 words, low address bits).
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_r_w) mem_f[mem_addr[3:0]] <= mem_datain;
      else         mem_out <= mem_f[mem_addr[3:0]];
    end
  end

  always @(posedge clk) begin
    if (nf_mem_en) begin
      if (nf_mem_r_w) mem_nf[nf_mem_addr[3:0]] <= nf_mem_datain;
      else            nf_mem_out <= mem_nf[nf_mem_addr[3:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Data-port access, waits (bounded) for d_ack on the FAIR=1 instance.
  task automatic data_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bit seen;
    seen = 0;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (d_ack) begin
        seen = 1;
        break;
      end
    end
    check_eq("data_access_ack", {15'd0, seen}, 16'd1);
    d_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_f[i]  = 16'h0000;
      mem_nf[i] = 16'h0000;
    end

    // Reset state
    #1;
    check_eq("rst_mem_en", {15'd0, mem_en}, 16'd0);
    check_eq("rst_busy", {15'd0, busy}, 16'd0);
    check_eq("rst_grant", {15'd0, grant}, 16'd0);
    check_eq("rst_mem_addr", mem_addr, 16'h0000);
    check_eq("rst_if_rdata", if_rdata, 16'h0000);
    check_eq("rst_d_rdata", d_rdata, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Preload word 1 through the data port
    data_access(1'b1, 16'h0001, 16'h00A5);
    check_eq("preload_d_rdata", d_rdata, 16'h0000);

    // Data write, detailed
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0002; d_wdata = 16'h00FE;
    tick();  // E0
    check_eq("wr_grant", {15'd0, grant}, 16'd1);
    check_eq("wr_mem_en", {15'd0, mem_en}, 16'd1);
    check_eq("wr_mem_r_w", {15'd0, mem_r_w}, 16'd1);
    check_eq("wr_mem_datain", mem_datain, 16'h00FE);
    check_eq("wr_mem_addr", mem_addr, 16'h0002);
    tick();  // E1
    check_eq("wr_mem_en_off", {15'd0, mem_en}, 16'd0);
    check_eq("wr_mem_r_w_off", {15'd0, mem_r_w}, 16'd0);
    check_eq("wr_mem_addr_hold", mem_addr, 16'h0002);
    tick();  // E2
    check_eq("wr_d_ack", {15'd0, d_ack}, 16'd1);
    check_eq("wr_d_rdata_unch", d_rdata, 16'h0000);
    d_req = 1'b0;
    tick();  // E3
    check_eq("wr_d_ack_off", {15'd0, d_ack}, 16'd0);
    check_eq("wr_busy_off", {15'd0, busy}, 16'd0);
    tick();

    // Data read back
    data_access(1'b0, 16'h0002, 16'h0000);
    check_eq("rd_d_rdata", d_rdata, 16'h00FE);

    // Fetch read
    if_req = 1'b1; if_addr = 16'h0001;
    tick();  // E0
    check_eq("f_grant", {15'd0, grant}, 16'd0);
    check_eq("f_mem_en", {15'd0, mem_en}, 16'd1);
    check_eq("f_mem_r_w", {15'd0, mem_r_w}, 16'd0);
    check_eq("f_mem_datain", mem_datain, 16'h0000);
    check_eq("f_busy", {15'd0, busy}, 16'd1);
    tick();  // E1
    check_eq("f_mem_en_1cyc", {15'd0, mem_en}, 16'd0);
    check_eq("f_if_ack_early", {15'd0, if_ack}, 16'd0);
    tick();  // E2
    check_eq("f_if_ack", {15'd0, if_ack}, 16'd1);
    check_eq("f_if_rdata", if_rdata, 16'h00A5);
    if_req = 1'b0;
    tick();  // E3
    check_eq("f_busy_low", {15'd0, busy}, 16'd0);
    check_eq("f_if_ack_low", {15'd0, if_ack}, 16'd0);
    tick();  // E4: dropped req must not be re-granted
    check_eq("f_no_regrant", {15'd0, busy}, 16'd0);
    check_eq("f_if_rdata_hold", if_rdata, 16'h00A5);

    // Ties: reset so the first FAIR tie goes to fetch
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 16'h0001;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c % 4 == 0) begin
        check_eq($sformatf("tie_f_grant_%0d", c / 4), {15'd0, grant}, 16'((c / 4) % 2));
        check_eq($sformatf("tie_nf_grant_%0d", c / 4), {15'd0, nf_grant}, 16'd1);
      end
      if (c % 4 == 2) begin
        check_eq($sformatf("tie_f_if_ack_%0d", c / 4), {15'd0, if_ack}, 16'((c / 4) % 2 == 0));
        check_eq($sformatf("tie_f_d_ack_%0d", c / 4), {15'd0, d_ack}, 16'((c / 4) % 2 == 1));
        check_eq($sformatf("tie_nf_d_ack_%0d", c / 4), {15'd0, nf_d_ack}, 16'd1);
        check_eq($sformatf("tie_nf_if_ack_%0d", c / 4), {15'd0, nf_if_ack}, 16'd0);
      end
      if (c % 4 == 3) begin
        check_eq($sformatf("tie_busy_low_%0d", c / 4), {15'd0, busy}, 16'd0);
      end
    end
    d_req = 1'b0;
    tick();  // fetch alone
    check_eq("solo_f_grant", {15'd0, grant}, 16'd0);
    check_eq("solo_nf_grant", {15'd0, nf_grant}, 16'd0);
    check_eq("solo_nf_busy", {15'd0, nf_busy}, 16'd1);
    tick();
    tick();
    check_eq("solo_nf_if_ack", {15'd0, nf_if_ack}, 16'd1);
    check_eq("solo_nf_if_rdata", nf_if_rdata, 16'h00A5);
    if_req = 1'b0;
    tick();
    tick();

    // Late request: d_req arrives during the fetch's ACCESS
    if_req = 1'b1; if_addr = 16'h0001;
    tick();  // E0
    check_eq("late_grant_f", {15'd0, grant}, 16'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
    tick();  // E1
    check_eq("late_mem_addr_f", mem_addr, 16'h0001);
    tick();  // E2
    check_eq("late_if_ack", {15'd0, if_ack}, 16'd1);
    check_eq("late_if_rdata", if_rdata, 16'h00A5);
    check_eq("late_no_d_ack", {15'd0, d_ack}, 16'd0);
    if_req = 1'b0;
    tick();  // E3
    check_eq("late_idle", {15'd0, busy}, 16'd0);
    tick();  // E4
    check_eq("late_grant_d", {15'd0, grant}, 16'd1);
    check_eq("late_mem_addr_d", mem_addr, 16'h0002);
    tick();  // E5
    check_eq("late_no_ack_e5", {15'd0, d_ack | if_ack}, 16'd0);
    tick();  // E6
    check_eq("late_d_ack", {15'd0, d_ack}, 16'd1);
    check_eq("late_d_rdata", d_rdata, 16'h00FE);
    check_eq("late_no_if_ack", {15'd0, if_ack}, 16'd0);
    d_req = 1'b0;
    tick();
    check_eq("late_d_ack_off", {15'd0, d_ack}, 16'd0);
    tick();

    // Reset mid-write
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0003; d_wdata = 16'h1234;
    tick();  // E0, now in ACCESS
    check_eq("rmw_mem_en", {15'd0, mem_en}, 16'd1);
    check_eq("rmw_mem_r_w", {15'd0, mem_r_w}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rmw_mem_en_drop", {15'd0, mem_en}, 16'd0);
    check_eq("rmw_mem_r_w_drop", {15'd0, mem_r_w}, 16'd0);
    check_eq("rmw_busy_drop", {15'd0, busy}, 16'd0);
    check_eq("rmw_mem_addr_rst", mem_addr, 16'h0000);
    check_eq("rmw_d_rdata_rst", d_rdata, 16'h0000);
    check_eq("rmw_if_rdata_rst", if_rdata, 16'h0000);
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq($sformatf("rmw_no_d_ack_%0d", c), {15'd0, d_ack}, 16'd0);
    end
    data_access(1'b0, 16'h0002, 16'h0000);
    check_eq("rmw_fresh_rd", d_rdata, 16'h00FE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
